rv_exec_datapath: RTL and testbench
===================================

Name: rv_exec_datapath

Overview:
Parametrised XLEN-wide execution datapath for the RV64I core, replacing the 16-bit datapath. It contains a register file with x0 hardwired to zero, A/B operand registers, an ALU/shifter, a C result register and a 4-bit status register. Operations run under a start/busy/done handshake. Shifts execute iteratively, one bit per cycle, unless the barrel-shifter option is compiled in. Sits between the control FSM, which drives all selects, and memory/PC logic.

Parameters:
XLEN, 64, datapath width in bits; power of two, at least 8.
NREGS, 32, register-file depth; entry 0 reads as zero. Derived localparams: AW = $clog2(NREGS), SW = $clog2(XLEN).

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  AW  read port 1 address (feeds A)
rs2_addr  in  AW  read port 2 address (feeds B)
wr_en  in  1  register-file write enable
wr_addr  in  AW  write address
wr_sel  in  2  write-data select: 0 = C, 1 = pc zero-extended, 2 = imm, 3 = mdata
pc  in  XLEN  program counter
imm  in  XLEN  sign-extended immediate
mdata  in  XLEN  memory read data
load_a  in  1  load A from read port 1
load_b  in  1  load B from read port 2
a_zero  in  1  ALU operand A forced to 0
b_imm  in  1  ALU operand B = imm instead of B
alu_op  in  4  operation code
set_flags  in  1  update status on completion
start  in  1  begin operation
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
c_out  out  XLEN  C register
flags  out  4  {N, Z, C, V}

Behaviour:
- Reset (asynchronous assert, synchronous release): all register-file entries, A, B, C, flags, busy and done go to 0; the FSM goes to IDLE. Reset mid-operation aborts it with no done pulse.
- Register file:
  - Reads are combinational.
  - A write occurs on the rising edge when wr_en is high and wr_addr != 0; writes to entry 0 are discarded.
  - Writes are accepted in any FSM state.
  - With wr_sel = 0, the value written is the pre-edge C.
- A/B registers load on the rising edge when load_a/load_b are high; otherwise they hold.
- Operand mux: opA = a_zero ? 0 : A; opB = b_imm ? imm : B.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed) and 6 SLTU produce 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA; shift amount = opB[SW-1:0].
  - 10-15 are reserved and produce result 0.
- FSM states IDLE, SHIFT, WB:
  - IDLE: when start is high at an edge, capture opA, opB, alu_op and set_flags into working registers, and set busy = 1.
    - If the op is a shift with amount > 0, go to SHIFT with count = amount.
    - Otherwise go to WB.
  - SHIFT: each edge, shift the working value one bit (SRA replicates the MSB) and decrement count. Move to WB on the edge where count reaches 0.
  - WB: on the edge, load C with the result and, if the captured set_flags is high, load flags. Clear busy, set done = 1 for exactly the next cycle, and return to IDLE.
- Latency: start at edge k gives C valid and done high after edge k+2 for non-shift ops, and after edge k+2+amount for iterative shifts.
- start is ignored while busy, including in WB. A start in the cycle done is high is accepted.
- Operands are captured at start, so later A/B/imm changes do not affect an in-flight op.
- Flags, computed on the XLEN-bit result:
  - N = result MSB; Z = (result == 0).
  - C = carry-out of opA + opB (ADD), or of opA + ~opB + 1 (SUB); 0 for other ops.
  - V = signed overflow for ADD/SUB; 0 otherwise.

Optional Feature:
RV_DP_BARREL_SHIFT_EN
- Defined: shifts are computed combinationally in one step. The SHIFT state is never entered and every op has the 2-edge latency.
- Undefined: iterative one-bit-per-cycle shifting as described in Behaviour.
- Results and flags are identical in both builds.

Test Plan:
- Reset with rst_n low mid-SHIFT -> busy = 0, done never pulses, c_out = 0, flags = 0, x5 reads 0.
- Write x1 = imm 5, x2 = imm -3 (wr_sel = 2); load A = x1, B = x2; ADD with set_flags -> done 2 edges after start, c_out = 2, flags = {0,0,1,0}.
- SUB 0x7FFF_FFFF_FFFF_FFFF - (-1) -> c_out = 0x8000_0000_0000_0000, N = 1, V = 1; wr_addr = 0 write of C -> x0 still reads 0.
- SRA of 0xF000_0000_0000_0000 by B = 4 -> c_out = 0xFF00_0000_0000_0000; done 6 edges after start (2 edges with RV_DP_BARREL_SHIFT_EN); shift by 0 -> 2 edges, value unchanged.
- start pulsed while busy, and B reloaded mid-shift -> no second op, result from captured operands only, exactly one done pulse.
- SLTU 1 vs 0xFFFF_FFFF_FFFF_FFFF -> 1; SLT same operands -> 0; reserved op 12 -> c_out = 0, Z = 1 only if set_flags = 1.

Source files
------------

// File: rtl/rv_exec_datapath_if.sv
// Control-side bundle for rv_exec_datapath: register-file addressing, operand/ALU selects,
// start/busy/done handshake and the C/status results.
interface rv_exec_datapath_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [1:0]      wr_sel;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] mdata;
    logic            load_a;
    logic            load_b;
    logic            a_zero;
    logic            b_imm;
    logic [3:0]      alu_op;
    logic            set_flags;
    logic            start;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] c_out;
    logic [3:0]      flags;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_sel, pc, imm, mdata,
               load_a, load_b, a_zero, b_imm, alu_op, set_flags, start,
        input  busy, done, c_out, flags
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_sel, pc, imm, mdata,
               load_a, load_b, a_zero, b_imm, alu_op, set_flags, start,
        output busy, done, c_out, flags
    );
endinterface

// File: rtl/rv_exec_datapath.sv
// XLEN-wide execution datapath: register file, A/B operand regs, ALU/shifter, C and {N,Z,C,V} status.
// Build option RV_DP_BARREL_SHIFT_EN replaces the one-bit-per-cycle shifter with a single-step barrel shifter.
module rv_exec_datapath #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input logic               clk,
    input logic               rst_n,
    rv_exec_datapath_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; captures operands when it arrives
    // SHIFT | iterative shift, one bit per edge, count runs down to 0
    // WB    | load C (and flags if requested); done pulses the following cycle
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] a_q, b_q, c_q, wdata, op_a, op_b;
    logic [XLEN-1:0] w_a, w_b, b_eff, result, shift_res;
    logic [XLEN:0]   sum;
    logic [3:0]      w_op, flags_q, flags_d;
    logic            w_setf, done_q, busy, is_arith, carry, ovf, accept;

    assign accept = (state_q == IDLE) && bus.start;

    always_comb begin
        unique case (bus.wr_sel)
            2'd0:    wdata = c_q;
            2'd1:    wdata = bus.pc;
            2'd2:    wdata = bus.imm;
            default: wdata = bus.mdata;
        endcase
    end

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.wr_en && bus.wr_addr != AW'(0)) begin
            rf[bus.wr_addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (bus.load_a) a_q <= rf[bus.rs1_addr];
            if (bus.load_b) b_q <= rf[bus.rs2_addr];
        end
    end

    assign op_a = bus.a_zero ? '0 : a_q;
    assign op_b = bus.b_imm ? bus.imm : b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_a    <= '0;
            w_b    <= '0;
            w_op   <= '0;
            w_setf <= 1'b0;
        end else if (accept) begin
            w_a    <= op_a;
            w_b    <= op_b;
            w_op   <= bus.alu_op;
            w_setf <= bus.set_flags;
        end
    end

`ifndef RV_DP_BARREL_SHIFT_EN
    logic [XLEN-1:0] shv;
    logic [SW-1:0]   cnt;
    logic            start_shift;

    assign start_shift = (bus.alu_op inside {4'd7, 4'd8, 4'd9}) && (op_b[SW-1:0] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shv <= '0;
            cnt <= '0;
        end else if (accept) begin
            shv <= op_a;
            cnt <= op_b[SW-1:0];
        end else if (state_q == SHIFT) begin
            cnt <= cnt - SW'(1);
            case (w_op)
                4'd7:    shv <= shv << 1;
                4'd8:    shv <= shv >> 1;
                default: shv <= {shv[XLEN-1], shv[XLEN-1:1]};
            endcase
        end
    end

    assign shift_res = shv;
`else
    always_comb begin
        case (w_op)
            4'd7:    shift_res = w_a << w_b[SW-1:0];
            4'd8:    shift_res = w_a >> w_b[SW-1:0];
            default: shift_res = $signed(w_a) >>> w_b[SW-1:0];
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifndef RV_DP_BARREL_SHIFT_EN
                    state_d = start_shift ? SHIFT : WB;
`else
                    state_d = WB;
`endif
                end
            end
`ifndef RV_DP_BARREL_SHIFT_EN
            SHIFT:   if (cnt == SW'(1)) state_d = WB;
`else
            SHIFT:   state_d = WB;
`endif
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // SUB reuses the adder as opA + ~opB + 1 so carry and overflow come out of the same sum.
    always_comb begin
        is_arith = (w_op == 4'd0) || (w_op == 4'd1);
        b_eff    = (w_op == 4'd1) ? ~w_b : w_b;
        sum      = {1'b0, w_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, (w_op == 4'd1)};
        result   = '0;
        case (w_op)
            4'd0, 4'd1: result = sum[XLEN-1:0];
            4'd2:       result = w_a & w_b;
            4'd3:       result = w_a | w_b;
            4'd4:       result = w_a ^ w_b;
            4'd5:       result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            4'd6:       result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            4'd7, 4'd8, 4'd9: result = shift_res;
            default:    result = '0;
        endcase
        carry   = is_arith && sum[XLEN];
        ovf     = is_arith && (w_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != w_a[XLEN-1]);
        flags_d = {result[XLEN-1], (result == '0), carry, ovf};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == WB);
            if (state_q == WB) begin
                c_q <= result;
                if (w_setf) flags_q <= flags_d;
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.c_out = c_q;
    assign bus.flags = flags_q;
endmodule

// File: tb/tb_rv_exec_datapath.sv
// Directed bench for rv_exec_datapath: vector table for ALU results/flags/latency plus handshake and reset sequences.
module tb_rv_exec_datapath;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
`ifdef RV_DP_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [63:0] c;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vt[17];

    rv_exec_datapath_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    rv_exec_datapath #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_imm(input logic [4:0] addr, input logic [63:0] val);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_sel  = 2'd2;
        bus.imm     = val;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic ld(input logic [4:0] r1, input logic [4:0] r2);
        bus.rs1_addr = r1;
        bus.rs2_addr = r2;
        bus.load_a   = 1'b1;
        bus.load_b   = 1'b1;
        tick();
        bus.load_a   = 1'b0;
        bus.load_b   = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic setf, input logic az, input logic bi,
                          output int lat);
        bus.alu_op    = op;
        bus.set_flags = setf;
        bus.a_zero    = az;
        bus.b_imm     = bi;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: op %0d got no done within %0d edges, required done", op, lat);
        end
    endtask

    initial begin
        int lat, pulses, first, n;
        logic seen;

        vt[0]  = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 4'd0, 64'd2, 4'b0010, 2};
        vt[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 64'h8000_0000_0000_0000, 4'b1001, 2};
        vt[2]  = '{64'hF000_0000_0000_0000, 64'd4, 4'd9, 64'hFF00_0000_0000_0000, 4'b1000, 6};
        vt[3]  = '{64'hF000_0000_0000_0000, 64'd0, 4'd9, 64'hF000_0000_0000_0000, 4'b1000, 2};
        vt[4]  = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 64'd1, 4'b0000, 2};
        vt[5]  = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 64'd0, 4'b0100, 2};
        vt[6]  = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd12, 64'd0, 4'b0100, 2};
        vt[7]  = '{64'd1, 64'd63, 4'd7, 64'h8000_0000_0000_0000, 4'b1000, 65};
        vt[8]  = '{64'h8000_0000_0000_0000, 64'd1, 4'd8, 64'h4000_0000_0000_0000, 4'b0000, 3};
        vt[9]  = '{64'hF0F0, 64'hFF00, 4'd2, 64'hF000, 4'b0000, 2};
        vt[10] = '{64'hF0F0, 64'h0F0F, 4'd3, 64'hFFFF, 4'b0000, 2};
        vt[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 64'd0, 4'b0100, 2};
        vt[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 64'd0, 4'b0110, 2};
        vt[13] = '{64'd5, 64'd5, 4'd1, 64'd0, 4'b0110, 2};
        vt[14] = '{64'd0, 64'd1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 2};
        vt[15] = '{64'h7000_0000_0000_0000, 64'd4, 4'd9, 64'h0700_0000_0000_0000, 4'b0000, 6};
        vt[16] = '{64'd1, 64'h44, 4'd7, 64'h10, 4'b0000, 6};

        bus.rs1_addr = '0; bus.rs2_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_sel = 2'd0; bus.pc = '0; bus.imm = '0; bus.mdata = '0;
        bus.load_a = 1'b0; bus.load_b = 1'b0; bus.a_zero = 1'b0; bus.b_imm = 1'b0;
        bus.alu_op = 4'd0; bus.set_flags = 1'b0; bus.start = 1'b0;

        repeat (3) tick();
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_c", bus.c_out, 64'd0);
        chk("reset_flags", {60'd0, bus.flags}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            wr_imm(5'd1, vt[i].a);
            wr_imm(5'd2, vt[i].b);
            ld(5'd1, 5'd2);
            run_op(vt[i].op, 1'b1, 1'b0, 1'b0, lat);
            chk($sformatf("vec%0d_c", i), bus.c_out, vt[i].c);
            chk($sformatf("vec%0d_flags", i), {60'd0, bus.flags}, {60'd0, vt[i].f});
            chk($sformatf("vec%0d_lat", i), 64'(lat), BARREL ? 64'd2 : 64'(vt[i].lat));
        end

        // C written back: x0 discards it, x3 keeps it
        wr_imm(5'd1, 64'h7FFF_FFFF_FFFF_FFFF);
        wr_imm(5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        ld(5'd1, 5'd2);
        run_op(4'd1, 1'b1, 1'b0, 1'b0, lat);
        chk("sub_c", bus.c_out, 64'h8000_0000_0000_0000);
        bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_addr = 5'd0;
        tick();
        bus.wr_addr = 5'd3;
        tick();
        bus.wr_en = 1'b0;
        ld(5'd0, 5'd0);
        run_op(4'd0, 1'b0, 1'b0, 1'b0, lat);
        chk("x0_reads_zero", bus.c_out, 64'd0);
        ld(5'd3, 5'd0);
        run_op(4'd0, 1'b0, 1'b0, 1'b0, lat);
        chk("x3_from_c", bus.c_out, 64'h8000_0000_0000_0000);

        // reserved op without set_flags keeps flags; back-to-back start in the done cycle
        wr_imm(5'd1, 64'h8000_0000_0000_0000);
        ld(5'd1, 5'd0);
        run_op(4'd0, 1'b1, 1'b0, 1'b0, lat);
        chk("pre_flags", {60'd0, bus.flags}, 64'b1000);
        run_op(4'd12, 1'b0, 1'b0, 1'b0, lat);
        chk("rsv_nf_c", bus.c_out, 64'd0);
        chk("rsv_nf_flags", {60'd0, bus.flags}, 64'b1000);
        bus.imm = 64'd10;
        run_op(4'd0, 1'b1, 1'b1, 1'b1, lat);
        chk("b2b_c", bus.c_out, 64'd10);
        chk("b2b_flags", {60'd0, bus.flags}, 64'b0000);
        chk("b2b_lat", 64'(lat), 64'd2);

        // start while busy and B reloaded mid-operation must not disturb the captured op
        wr_imm(5'd1, 64'hF000_0000_0000_0000);
        wr_imm(5'd2, 64'd4);
        wr_imm(5'd6, 64'd1);
        ld(5'd1, 5'd2);
        bus.a_zero = 1'b0; bus.b_imm = 1'b0;
        bus.alu_op = 4'd9; bus.set_flags = 1'b1; bus.start = 1'b1;
        tick();
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
        bus.alu_op = 4'd8; bus.rs2_addr = 5'd6; bus.load_b = 1'b1; bus.imm = 64'd0;
        tick();
        bus.start = 1'b0; bus.load_b = 1'b0;
        pulses = 0; first = 0; n = 2;
        repeat (20) begin
            if (bus.done) begin
                pulses++;
                if (first == 0) first = n;
            end
            tick();
            n++;
        end
        chk("busy_pulses", 64'(pulses), 64'd1);
        chk("busy_done_edge", 64'(first), BARREL ? 64'd2 : 64'd6);
        chk("busy_c", bus.c_out, 64'hFF00_0000_0000_0000);
        chk("busy_flags", {60'd0, bus.flags}, 64'b1000);
        chk("busy_idle", {63'd0, bus.busy}, 64'd0);

        // reset in the middle of a long shift
        wr_imm(5'd5, 64'h1234);
        wr_imm(5'd7, 64'd40);
        ld(5'd5, 5'd7);
        bus.alu_op = 4'd8; bus.set_flags = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_mid_done", {63'd0, bus.done}, 64'd0);
        chk("rst_mid_c", bus.c_out, 64'd0);
        chk("rst_mid_flags", {60'd0, bus.flags}, 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        chk("rst_mid_no_done", {63'd0, seen}, 64'd0);
        ld(5'd5, 5'd0);
        run_op(4'd0, 1'b0, 1'b0, 1'b0, lat);
        chk("rst_mid_x5", bus.c_out, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
